// File: rtl/wr_req_scheduler_pkg.sv
// Shared constants for the write-request scheduler and AXI wrapper.
// Holds the clog2 helper, the PU id width rule and the FSM state type.
package wr_req_scheduler_pkg;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // PU id width: one bit wider than the index, upper bits zero.
  function automatic int pu_id_w(input int num_pu);
    return clog2(num_pu) + 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/wr_req_scheduler_order_fifo.sv
// wr_order_fifo: in-order FIFO of issued PU ids; count = outstanding.
// Ports: push/din, pop/dout (bypasses din when empty), empty, full, count.
module wr_order_fifo
  import wr_req_scheduler_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0] wp_q, wp_d;
  logic [IDX_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] p
  );
    if (p == IDX_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;

  // Empty FIFO with a same-cycle push: the popped entry is din.
  assign dout    = empty ? din : mem_q[rp_q];
  assign do_push = push;
  assign do_pop  = pop && (!empty || push);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = nxt(wp_q);
    if (do_pop)  rp_d = nxt(rp_q);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/wr_req_scheduler.sv
// Round-robin write-request arbiter/sequencer for the AXI write port.
// Ports: per-PU req/addr/size in, grant/done pulses out; wr_* to wrapper.
module wr_req_scheduler
  import wr_req_scheduler_pkg::*;
#(
  parameter int NUM_PU          = 2,
  parameter int ADDR_W          = 32,
  parameter int TX_SIZE_WIDTH   = 10,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PU_ID_W         = pu_id_w(NUM_PU)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PU-1:0]               pu_wr_req,
  input  logic [NUM_PU*ADDR_W-1:0]        pu_wr_addr,
  input  logic [NUM_PU*TX_SIZE_WIDTH-1:0] pu_wr_size,
  output logic [NUM_PU-1:0]               pu_wr_grant,
  output logic [NUM_PU-1:0]               pu_wr_done,
  output logic                            wr_req,
  output logic [PU_ID_W-1:0]              wr_pu_id,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [TX_SIZE_WIDTH-1:0]        wr_req_size,
  input  logic                            wr_ready,
  input  logic                            wr_done,
  output logic [clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                            err_spurious_done
);

  localparam int CNT_W = clog2(MAX_OUTSTANDING) + 1;
  localparam int RR_W  = (NUM_PU > 1) ? clog2(NUM_PU) : 1;

  wr_state_e                state_q, state_d;
  logic [RR_W-1:0]          rr_q, rr_d;
  logic [PU_ID_W-1:0]       id_q, id_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [TX_SIZE_WIDTH-1:0] size_q, size_d;
  logic [NUM_PU-1:0]        done_q, done_d;
  logic                     err_q, err_d;

  logic                     found;
  logic [RR_W-1:0]          sel;
  logic                     capture;
  logic                     accept;
  logic                     pop;
  logic                     f_empty;
  logic                     f_full;
  logic [PU_ID_W-1:0]       head;
  logic [CNT_W-1:0]         cnt;

  // First requester at or after the RR pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_PU; k++) begin
      if (!found &&
          pu_wr_req[(int'(rr_q) + k) % NUM_PU]) begin
        found = 1'b1;
        sel   = RR_W'((int'(rr_q) + k) % NUM_PU);
      end
    end
  end

  assign capture = (state_q == IDLE) && found
                && !f_full && !reset;
  assign accept  = (state_q == ISSUE) && wr_ready;
  assign pop     = wr_done && (!f_empty || accept);

  wr_order_fifo #(
    .W     (PU_ID_W),
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (id_q),
    .pop   (pop),
    .dout  (head),
    .empty (f_empty),
    .full  (f_full),
    .count (cnt)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    size_d      = size_q;
    err_d       = err_q;
    done_d      = '0;
    pu_wr_grant = '0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          pu_wr_grant = NUM_PU'(1) << sel;
          id_d    = PU_ID_W'(sel);
          addr_d  = pu_wr_addr[sel*ADDR_W +: ADDR_W];
          size_d  = pu_wr_size[sel*TX_SIZE_WIDTH
                               +: TX_SIZE_WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_ready) begin
          state_d = IDLE;
          if (id_q[RR_W-1:0] == RR_W'(NUM_PU - 1))
            rr_d = '0;
          else
            rr_d = id_q[RR_W-1:0] + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop)
      done_d = NUM_PU'(1) << head;
    if (wr_done && !pop)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_req            = (state_q == ISSUE);
  assign wr_pu_id          = id_q;
  assign wr_addr           = addr_q;
  assign wr_req_size       = size_q;
  assign pu_wr_done        = done_q;
  assign outstanding       = cnt;
  assign err_spurious_done = err_q;

endmodule

// File: tb/tb_wr_req_scheduler.sv
// Scoreboard bench for wr_req_scheduler: transaction model vs DUT.
// Directed scenarios followed by a randomized soak.
module tb_wr_req_scheduler;

  localparam int N    = 2;
  localparam int AW   = 32;
  localparam int SW   = 10;
  localparam int MAXO = 4;
  localparam int IDW  = 2;
  localparam int CW   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      pu_wr_req;
  logic [N*AW-1:0]   pu_wr_addr;
  logic [N*SW-1:0]   pu_wr_size;
  logic [N-1:0]      pu_wr_grant;
  logic [N-1:0]      pu_wr_done;
  logic              wr_req;
  logic [IDW-1:0]    wr_pu_id;
  logic [AW-1:0]     wr_addr;
  logic [SW-1:0]     wr_req_size;
  logic              wr_ready;
  logic              wr_done;
  logic [CW-1:0]     outstanding;
  logic              err_spurious_done;

  logic [AW-1:0] addr_a [N];
  logic [SW-1:0] size_a [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pu_wr_addr[i*AW +: AW] = addr_a[i];
      pu_wr_size[i*SW +: SW] = size_a[i];
    end
  end

  always #5 clk = ~clk;

  wr_req_scheduler #(
    .NUM_PU          (N),
    .ADDR_W          (AW),
    .TX_SIZE_WIDTH   (SW),
    .MAX_OUTSTANDING (MAXO),
    .PU_ID_W         (IDW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pu_wr_req         (pu_wr_req),
    .pu_wr_addr        (pu_wr_addr),
    .pu_wr_size        (pu_wr_size),
    .pu_wr_grant       (pu_wr_grant),
    .pu_wr_done        (pu_wr_done),
    .wr_req            (wr_req),
    .wr_pu_id          (wr_pu_id),
    .wr_addr           (wr_addr),
    .wr_req_size       (wr_req_size),
    .wr_ready          (wr_ready),
    .wr_done           (wr_done),
    .outstanding       (outstanding),
    .err_spurious_done (err_spurious_done)
  );

  typedef struct {
    bit            skip;
    logic [N-1:0]  grant;
    logic          req;
    logic [IDW-1:0] id;
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    logic [N-1:0]  done;
    int            out;
    logic          err;
  } exp_t;

  exp_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Transaction-level reference state.
  int             rr       = 0;
  bit             busy     = 0;
  logic [IDW-1:0] cur_id   = '0;
  logic [AW-1:0]  cur_addr = '0;
  logic [SW-1:0]  cur_size = '0;
  int             orderq[$];
  logic [N-1:0]   done_pend  = '0;
  bit             merr       = 0;
  logic [N-1:0]   last_grant = '0;

  // Model: inputs are stable at negedge; push one expected record.
  always @(negedge clk) begin : model
    exp_t e;
    int   p;
    bit   hit;
    logic [N-1:0] nd;
    e.skip  = reset;
    e.grant = '0;
    e.req   = busy;
    e.id    = cur_id;
    e.addr  = cur_addr;
    e.size  = cur_size;
    e.done  = done_pend;
    e.out   = orderq.size();
    e.err   = merr;
    if (reset) begin
      rr = 0; busy = 0; cur_id = '0;
      cur_addr = '0; cur_size = '0;
      orderq.delete(); done_pend = '0; merr = 0;
    end else begin
      nd = '0;
      if (!busy && pu_wr_req != '0 && orderq.size() < MAXO) begin
        hit = 0; p = 0;
        for (int k = 0; k < N; k++) begin
          if (!hit && pu_wr_req[(rr + k) % N]) begin
            hit = 1; p = (rr + k) % N;
          end
        end
        e.grant  = N'(1) << p;
        busy     = 1;
        cur_id   = IDW'(p);
        cur_addr = addr_a[p];
        cur_size = size_a[p];
      end else if (busy && wr_ready) begin
        orderq.push_back(int'(cur_id));
        rr   = (int'(cur_id) + 1) % N;
        busy = 0;
      end
      if (wr_done) begin
        if (orderq.size() > 0) nd = N'(1) << orderq.pop_front();
        else merr = 1;
      end
      done_pend = nd;
    end
    last_grant = e.grant;
    expq.push_back(e);
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the oldest expected record.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (expq.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard: got empty queue expected record");
    end else begin
      e = expq.pop_front();
      if (!e.skip) begin
        chk("grant", 64'(pu_wr_grant), 64'(e.grant));
        chk("wr_req", 64'(wr_req), 64'(e.req));
        chk("wr_pu_id", 64'(wr_pu_id), 64'(e.id));
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_size", 64'(wr_req_size), 64'(e.size));
        chk("pu_done", 64'(pu_wr_done), 64'(e.done));
        chk("outstanding", 64'(outstanding), 64'(e.out));
        chk("err", 64'(err_spurious_done), 64'(e.err));
      end
    end
  end

  // One cycle; a PU drops its request once granted.
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      pu_wr_req = pu_wr_req & ~last_grant;
    end
  endtask

  task automatic pulse_done();
    wr_done = 1'b1;
    tick(1);
    wr_done = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    pu_wr_req = '0;
    wr_ready  = 1'b0;
    wr_done   = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0;
      size_a[i] = '0;
    end
    tick(3);
    reset = 1'b0;
    tick(1);

    // Single request from PU1 and its completion.
    addr_a[1] = 32'h1000_0000;
    size_a[1] = 10'd16;
    wr_ready  = 1'b1;
    pu_wr_req = 2'b10;
    tick(4);
    pulse_done();
    tick(2);

    // Fairness with both PUs continuously requesting.
    addr_a[0] = 32'hA000_0000;
    size_a[0] = 10'd3;
    repeat (8) begin
      pu_wr_req = 2'b11;
      tick(1);
    end
    pu_wr_req = '0;
    tick(1);
    repeat (4) begin
      pulse_done();
      tick(1);
    end

    // Backpressure for 5 cycles in ISSUE.
    wr_ready  = 1'b0;
    pu_wr_req = 2'b01;
    tick(6);
    wr_ready = 1'b1;
    tick(2);
    pulse_done();
    tick(1);

    // Fill to MAX_OUTSTANDING with a fifth request pending.
    repeat (10) begin
      pu_wr_req = 2'b11;
      tick(1);
    end
    tick(3);
    pulse_done();
    tick(4);
    pu_wr_req = '0;
    for (int g = 0; g < 20 && orderq.size() > 0; g++) begin
      pulse_done();
      tick(1);
    end
    tick(2);

    // Accept and wr_done in the same cycle with one outstanding.
    pu_wr_req = 2'b01;
    tick(2);
    pu_wr_req = 2'b10;
    tick(1);
    wr_done = 1'b1;
    tick(1);
    wr_done = 1'b0;
    tick(2);
    pulse_done();
    tick(2);

    // Spurious wr_done on an empty FIFO.
    pulse_done();
    tick(2);

    // Reset while in ISSUE with one write in flight.
    pu_wr_req = 2'b10;
    tick(3);
    wr_ready  = 1'b0;
    pu_wr_req = 2'b01;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset     = 1'b0;
    pu_wr_req = '0;
    wr_ready  = 1'b1;
    tick(2);
    pulse_done();
    tick(3);

    // Randomized soak.
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!pu_wr_req[i] && $urandom_range(0, 2) == 0) begin
          pu_wr_req[i] = 1'b1;
          addr_a[i]    = $urandom;
          size_a[i]    = SW'($urandom);
        end
      end
      wr_ready = ($urandom_range(0, 9) < 7);
      wr_done  = ($urandom_range(0, 9) < 3);
      reset    = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    reset     = 1'b0;
    wr_done   = 1'b0;
    pu_wr_req = '0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
